// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: shared types and defaults for the PLL reset sequencer.
//   state_t      : sequencer state encoding
//   DEF_*        : default timings for a 27 MHz reference clock
//   cnt_width()  : width of the shared state counter, derived from the
//                  largest terminal count
package pll_reset_pkg;

  typedef enum logic [2:0] {
    RESET_PULSE,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 27000;  // 1 ms at 27 MHz
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_CNT_W         = 8;
  localparam int unsigned DEF_MAX_RETRIES   = 8;

  // The counter only ever holds 0 .. max-1, so clog2(max) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// bit_sync: N-stage single-bit synchroniser with synchronous active-high reset.
//   clk : destination clock
//   rst : synchronous active-high reset, clears all stages
//   d   : asynchronous input
//   q   : synchronised output (last stage)
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulse generator and downstream reset gate.
// Pulses the PLL reset at power-up, after a lock timeout and after lock loss
// in RUN; holds sys_rst until the synchronised lock has been stable.
// Optional feature macro: PLL_RETRY_LIMIT_EN (adds MAX_RETRIES, pll_fail and
// a terminal FAIL state after MAX_RETRIES lock timeouts).
//   refclk        : PLL reference clock
//   rst           : synchronous active-high reset
//   pll_locked    : PLL lock indicator, asynchronous to refclk
//   pll_rst       : active-high reset to the PLL
//   sys_rst       : active-high reset to downstream logic
//   ready         : high while in RUN
//   lock_loss_cnt : saturating count of lock losses seen in RUN
//   pll_fail      : (PLL_RETRY_LIMIT_EN only) retry limit exhausted
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W         = DEF_CNT_W
`ifdef PLL_RETRY_LIMIT_EN
  , parameter int unsigned MAX_RETRIES = DEF_MAX_RETRIES
`endif
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt
`ifdef PLL_RETRY_LIMIT_EN
  , output logic           pll_fail
`endif
);

  localparam int unsigned CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

`ifdef PLL_RETRY_LIMIT_EN
  localparam int unsigned RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
  logic [RW-1:0] retry;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic          locked_s;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Outputs are assigned alongside each transition so they take their new
  // value on the first cycle spent in the new state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= RESET_PULSE;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
`ifdef PLL_RETRY_LIMIT_EN
      retry         <= '0;
      pll_fail      <= 1'b0;
`endif
    end else begin
      case (state)
        RESET_PULSE: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_LOCK: begin
          // Lock is tested first so it wins over a coincident timeout.
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
            retry   <= retry + RW'(1);
            if (retry == RETRY_LAST) begin
              state    <= FAIL;
              pll_fail <= 1'b1;
            end else begin
              state <= RESET_PULSE;
            end
`else
            state   <= RESET_PULSE;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
            retry   <= '0;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RUN: begin
          if (!locked_s) begin
            state   <= RESET_PULSE;
            cnt     <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            if (lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
          end
        end

        // FAIL is terminal: outputs were set on entry and only rst leaves it.
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scenario-based self-checking bench for
// pll_reset_sequencer. Expected values are pushed to a scoreboard queue when
// stimulus is applied and popped when the corresponding DUT response is seen.
module tb_pll_reset_sequencer;

  localparam int unsigned RST   = 16;
  localparam int unsigned TO    = 100;
  localparam int unsigned ST    = 128;
  localparam int unsigned SS    = 2;
  localparam int unsigned CW    = 4;
  localparam int unsigned SAT   = (1 << CW) - 1;

  logic          refclk;
  logic          rst;
  logic          pll_locked;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic [CW-1:0] lock_loss_cnt;
`ifdef PLL_RETRY_LIMIT_EN
  logic          pll_fail;
`endif

  pll_reset_sequencer #(
`ifdef PLL_RETRY_LIMIT_EN
    .MAX_RETRIES   (3),
`endif
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (ST),
    .SYNC_STAGES   (SS),
    .CNT_W         (CW)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
`ifdef PLL_RETRY_LIMIT_EN
    , .pll_fail    (pll_fail)
`endif
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Waits (bounded) for a DUT output to reach lvl, counting falling edges.
  // sel: 0 = pll_rst, 1 = sys_rst, 2 = ready. n > limit means it never came.
  task automatic wait_for(input int sel, input logic lvl, input int unsigned limit,
                          output int unsigned n, output bit saw_prst);
    logic v;
    n = 0;
    saw_prst = 1'b0;
    while (n <= limit) begin
      @(negedge refclk);
      n++;
      if (pll_rst === 1'b1) saw_prst = 1'b1;
      case (sel)
        0:       v = pll_rst;
        1:       v = sys_rst;
        default: v = ready;
      endcase
      if (v === lvl) break;
    end
  endtask

  task automatic apply_rst(input int unsigned cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    pll_locked = 1'b1;
    rst = 1'b1;
    push("rst_pll_rst", 1); push("rst_sys_rst", 1); push("rst_ready", 0); push("rst_llc", 0);
    repeat (4) @(negedge refclk);
    obs = {31'b0, pll_rst};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = {31'b0, sys_rst};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = {31'b0, ready};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = 32'(lock_loss_cnt);
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
  endtask

  task automatic test_powerup();
    exp_t e;
    logic [31:0] obs;
    int unsigned n;
    bit saw;
    pll_locked = 1'b0;
    apply_rst(4);
    push("pwr_pll_rst_width", RST);
    wait_for(0, 1'b0, 60, n, saw);
    obs = n;
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    repeat (100 - n) @(negedge refclk);
    pll_locked = 1'b1;
    push("pwr_sys_rst_latency", SS + ST + 1);
    push("pwr_ready", 1);
    wait_for(1, 1'b0, 400, n, saw);
    obs = n;
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = {31'b0, ready};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [31:0] obs;
    int unsigned n;
    bit saw;
    bit sys_drop;
    pll_locked = 1'b0;
    apply_rst(2);
    wait_for(0, 1'b0, 60, n, saw);
    sys_drop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push("to_wait_span", TO);
      push("to_pulse_width", RST);
      wait_for(0, 1'b1, 300, n, saw);
      if (sys_rst !== 1'b1) sys_drop = 1'b1;
      obs = n;
      e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
      wait_for(0, 1'b0, 60, n, saw);
      if (sys_rst !== 1'b1) sys_drop = 1'b1;
      obs = n;
      e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    end
    push("to_sys_rst_held", 0);
    obs = {31'b0, sys_drop};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
  endtask

`ifdef PLL_RETRY_LIMIT_EN
  // Continues from test_timeout: two timeouts already counted.
  task automatic test_retry_limit();
    exp_t e;
    logic [31:0] obs;
    int unsigned n;
    bit saw;
    push("rl_fail_before", 0);
    obs = {31'b0, pll_fail};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    push("rl_third_timeout", TO);
    wait_for(0, 1'b1, 300, n, saw);
    obs = n;
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    pll_locked = 1'b1;
    push("rl_pll_fail", 1); push("rl_pll_rst_held", 1); push("rl_sys_rst_held", 1);
    repeat (300) @(negedge refclk);
    obs = {31'b0, pll_fail};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = {31'b0, pll_rst};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = {31'b0, sys_rst};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
  endtask
`endif

  // locked_s rises exactly on the cycle the WAIT_LOCK timeout expires.
  task automatic test_lock_timeout_tie();
    exp_t e;
    logic [31:0] obs;
    int unsigned n;
    bit saw;
    pll_locked = 1'b0;
    apply_rst(2);
    wait_for(0, 1'b0, 60, n, saw);
    repeat (TO - 1 - SS) @(negedge refclk);
    pll_locked = 1'b1;
    push("tie_sys_rst_latency", SS + ST + 1);
    push("tie_no_pll_pulse", 0);
    wait_for(1, 1'b0, 400, n, saw);
    obs = n;
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = {31'b0, saw};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
  endtask

  task automatic test_unstable();
    exp_t e;
    logic [31:0] obs;
    int unsigned n;
    bit saw;
    bit early;
    pll_locked = 1'b0;
    apply_rst(2);
    wait_for(0, 1'b0, 60, n, saw);
    pll_locked = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge refclk);
      if (sys_rst !== 1'b1 || pll_rst !== 1'b0) early = 1'b1;
    end
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    push("us_no_early_change", 0);
    push("us_sys_rst_latency", SS + ST + 1);
    push("us_no_pll_pulse", 0);
    wait_for(1, 1'b0, 400, n, saw);
    obs = {31'b0, early};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = n;
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = {31'b0, saw};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
  endtask

  // Starts in RUN (left there by test_unstable) with lock_loss_cnt = 0.
  task automatic test_run_loss();
    exp_t e;
    logic [31:0] obs;
    int unsigned n;
    bit saw;
    for (int i = 0; i < 20; i++) begin
      pll_locked = 1'b0;
      push("loss_sys_rst_latency", SS + 1);
      push("loss_pll_rst", 1);
      push("loss_ready", 0);
      push("loss_count", (i + 1 > SAT) ? SAT : i + 1);
      wait_for(1, 1'b1, 20, n, saw);
      obs = n;
      e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
      obs = {31'b0, pll_rst};
      e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
      obs = {31'b0, ready};
      e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
      obs = 32'(lock_loss_cnt);
      e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
      pll_locked = 1'b1;
      push("relock_ready_latency", RST + 1 + ST);
      wait_for(2, 1'b1, 400, n, saw);
      obs = n;
      e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    end
  endtask

  // Starts in RUN with a saturated lock_loss_cnt; resets from STABLE.
  task automatic test_mid_reset();
    exp_t e;
    logic [31:0] obs;
    int unsigned n;
    bit saw;
    pll_locked = 1'b0;
    wait_for(1, 1'b1, 20, n, saw);
    pll_locked = 1'b1;
    wait_for(0, 1'b0, 60, n, saw);
    repeat (60) @(negedge refclk);
    push("mr_in_stable_sys_rst", 1);
    push("mr_llc_before", SAT);
    obs = {31'b0, sys_rst};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = 32'(lock_loss_cnt);
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    push("mr_pll_rst", 1); push("mr_sys_rst", 1); push("mr_ready", 0); push("mr_llc", 0);
    apply_rst(1);
    obs = {31'b0, pll_rst};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = {31'b0, sys_rst};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = {31'b0, ready};
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    obs = 32'(lock_loss_cnt);
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    push("mr_restart_pulse", RST);
    push("mr_sys_rst_after_pulse", ST + 1);
    wait_for(0, 1'b0, 60, n, saw);
    obs = n;
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
    wait_for(1, 1'b0, 400, n, saw);
    obs = n;
    e = sb.pop_front(); checks++; if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    test_powerup();
    test_timeout();
`ifdef PLL_RETRY_LIMIT_EN
    test_retry_limit();
`endif
    test_lock_timeout_tie();
    test_unstable();
    test_run_loss();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
